// File: rtl/memory_access_unit.sv
// Memory-access stage: word-organised data memory with sized, sign/zero-extended loads,
// lane-masked stores, misalignment rejection, optional wait states and registered branch select.
//
//   state  | meaning
//   S_IDLE | ready; a valid request completes now (no wait states) or moves to S_WAIT
//   S_WAIT | captured access in flight; completes at the edge where cnt_q == 1
module memory_access_unit #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ctrl_branch,
    input  logic              ctrl_branch_ne,
    input  logic              zero,
    input  logic              ctrl_memRead,
    input  logic              ctrl_memWrite,
    input  logic [1:0]        ctrl_size,
    input  logic              ctrl_unsigned,
    input  logic [31:0]       mem_address,
    input  logic [DATA_W-1:0] write_data_into_mem,
    output logic              ctrl_pcSrc,
    output logic [DATA_W-1:0] read_data_from_mem,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              misaligned
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [OFF_W-1:0]   off_q;
    logic [1:0]         size_q;
    logic               uns_q;
    logic               wr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [DATA_W-1:0]  rdata_q;
    logic               busy_q, done_q, mis_q, pcsrc_q;
    logic [DATA_W-1:0]  mem_q [DEPTH];

    logic               req, req_bad, req_ok, idle, complete, wr_now;
    logic [IDX_W-1:0]   in_idx, a_idx;
    logic [OFF_W-1:0]   in_off, a_off;
    logic [1:0]         a_size;
    logic               a_uns, a_wr;
    logic [DATA_W-1:0]  a_wdata, wr_shift, bit_mask, rd_word, rd_shift, rd_ext;
    logic [BYTES-1:0]   lane_en;
    logic               unused_addr_hi;

    assign in_idx         = mem_address[IDX_W+OFF_W-1:OFF_W];
    assign in_off         = mem_address[OFF_W-1:0];
    assign unused_addr_hi = ^mem_address[31:IDX_W+OFF_W];
    assign idle           = (state_q == S_IDLE);
    assign req            = ctrl_memRead | ctrl_memWrite;

    always_comb begin
        req_bad = 1'b0;
        case (ctrl_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = in_off[0];
            default: req_bad = (in_off != '0);
        endcase
    end

    assign req_ok   = idle & req & ~req_bad;
    assign complete = idle ? (req_ok && (WAIT_CYCLES == 0)) : (cnt_q == CNT_W'(1));

    // In IDLE the access uses the live inputs; in WAIT it uses the values captured at acceptance.
    assign a_idx   = idle ? in_idx : idx_q;
    assign a_off   = idle ? in_off : off_q;
    assign a_size  = idle ? ctrl_size : size_q;
    assign a_uns   = idle ? ctrl_unsigned : uns_q;
    assign a_wr    = idle ? ctrl_memWrite : wr_q;
    assign a_wdata = idle ? write_data_into_mem : wdata_q;
    assign wr_now  = complete & a_wr;

    always_comb begin
        case (a_size)
            2'b00:   lane_en = BYTES'(1) << a_off;
            2'b01:   lane_en = BYTES'(3) << a_off;
            default: lane_en = '1;
        endcase
        bit_mask = '0;
        for (int l = 0; l < BYTES; l++) begin
            bit_mask[8*l +: 8] = {8{lane_en[l]}};
        end
        wr_shift = a_wdata << (8 * a_off);
        rd_word  = mem_q[a_idx];
        rd_shift = rd_word >> (8 * a_off);
        case (a_size)
            2'b00:   rd_ext = a_uns ? DATA_W'(rd_shift[7:0])  : DATA_W'($signed(rd_shift[7:0]));
            2'b01:   rd_ext = a_uns ? DATA_W'(rd_shift[15:0]) : DATA_W'($signed(rd_shift[15:0]));
            default: rd_ext = rd_word;
        endcase
    end

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                mem_q[w] <= '0;
            end else if (wr_now && (a_idx == IDX_W'(w))) begin
                mem_q[w] <= (mem_q[w] & ~bit_mask) | (wr_shift & bit_mask);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            mis_q   <= 1'b0;
            pcsrc_q <= 1'b0;
        end else begin
            done_q <= complete;
            mis_q  <= idle & req & req_bad;
            if (!busy_q) begin
                pcsrc_q <= ctrl_branch & (zero ^ ctrl_branch_ne);
            end
            if (complete && !a_wr) begin
                rdata_q <= rd_ext;
            end
            case (state_q)
                S_IDLE: begin
                    if (req_ok) begin
                        idx_q   <= in_idx;
                        off_q   <= in_off;
                        size_q  <= ctrl_size;
                        uns_q   <= ctrl_unsigned;
                        wr_q    <= ctrl_memWrite;
                        wdata_q <= write_data_into_mem;
                        if (WAIT_CYCLES != 0) begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES);
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ctrl_pcSrc         = pcsrc_q;
    assign read_data_from_mem = rdata_q;
    assign mem_busy           = busy_q;
    assign mem_done           = done_q;
    assign misaligned         = mis_q;
endmodule

// File: tb/tb_memory_access_unit.sv
// Bench for memory_access_unit: one instance without wait states and one with three, driven
// by the same requests; a byte-array model feeds per-instance response queues.
module tb_memory_access_unit;
    localparam int DEPTH  = 64;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_branch, ctrl_branch_ne, zero;
    logic        ctrl_memRead, ctrl_memWrite, ctrl_unsigned;
    logic [1:0]  ctrl_size;
    logic [31:0] mem_address, write_data_into_mem;

    logic        pc0, busy0, done0, mis0;
    logic [31:0] rd0;
    logic        pc3, busy3, done3, mis3;
    logic [31:0] rd3;

    memory_access_unit #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .ctrl_branch(ctrl_branch), .ctrl_branch_ne(ctrl_branch_ne),
        .zero(zero), .ctrl_memRead(ctrl_memRead), .ctrl_memWrite(ctrl_memWrite),
        .ctrl_size(ctrl_size), .ctrl_unsigned(ctrl_unsigned), .mem_address(mem_address),
        .write_data_into_mem(write_data_into_mem), .ctrl_pcSrc(pc0), .read_data_from_mem(rd0),
        .mem_busy(busy0), .mem_done(done0), .misaligned(mis0));

    memory_access_unit #(.DATA_W(32), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .reset(reset), .ctrl_branch(ctrl_branch), .ctrl_branch_ne(ctrl_branch_ne),
        .zero(zero), .ctrl_memRead(ctrl_memRead), .ctrl_memWrite(ctrl_memWrite),
        .ctrl_size(ctrl_size), .ctrl_unsigned(ctrl_unsigned), .mem_address(mem_address),
        .write_data_into_mem(write_data_into_mem), .ctrl_pcSrc(pc3), .read_data_from_mem(rd3),
        .mem_busy(busy3), .mem_done(done3), .misaligned(mis3));

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mis;
        logic [31:0] data;
    } resp_t;

    resp_t       sb0[$];
    resp_t       sb3[$];
    int          n_cmp = 0;
    int          n_err = 0;
    byte unsigned mem_b[NBYTES];
    logic [31:0] last_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
        last_rd = 32'h0;
    endfunction

    // Byte-addressed reference: little-endian bytes, natural alignment, write wins over read.
    function automatic void model(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                                  input logic [31:0] addr, input logic [31:0] wd,
                                  output bit has, output resp_t r);
        int nb, off, base;
        logic [31:0] v;
        has    = rd || wr;
        r.mis  = 1'b0;
        r.data = last_rd;
        if (!has) return;
        nb  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(addr % 32'd4);
        if ((off % nb) != 0) begin
            r.mis = 1'b1;
            return;
        end
        base = int'(addr % 32'(NBYTES));
        if (wr) begin
            for (int i = 0; i < nb; i++) mem_b[base+i] = wd[8*i +: 8];
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(mem_b[base+i]) << (8*i));
            if (!uns && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            last_rd = v;
            r.data  = v;
        end
    endfunction

    task automatic mon(input int k, input logic done, input logic mis, input logic [31:0] rd);
        resp_t r;
        string nm;
        nm = (k == 0) ? "dut0" : "dut3";
        if (!(done || mis)) return;
        if ((k == 0 && sb0.size() == 0) || (k == 1 && sb3.size() == 0)) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s unexpected response: done=%0b misaligned=%0b, none required", nm, done, mis);
            return;
        end
        if (k == 0) r = sb0.pop_front();
        else        r = sb3.pop_front();
        check({nm, " misaligned"}, 32'(mis), 32'(r.mis));
        check({nm, " done"}, 32'(done), 32'(!r.mis));
        check({nm, " read_data"}, rd, r.data);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            mon(0, done0, mis0, rd0);
            mon(1, done3, mis3, rd3);
        end
    end

    task automatic do_req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input bit abort3, input bit pc_hold);
        resp_t r;
        bit    has, valid;
        model(rd, wr, sz, uns, addr, wd, has, r);
        valid = has && !r.mis;
        @(negedge clk);
        if (has) begin
            sb0.push_back(r);
            if (!abort3) sb3.push_back(r);
        end
        ctrl_memRead        = rd;
        ctrl_memWrite       = wr;
        ctrl_size           = sz;
        ctrl_unsigned       = uns;
        mem_address         = addr;
        write_data_into_mem = wd;
        @(posedge clk);
        #1;
        check("dut0 busy", 32'(busy0), 32'h0);
        check("dut3 busy at accept", 32'(busy3), 32'(valid));
        check("dut0 done latency", 32'(done0), 32'(valid));
        check("dut3 misaligned pulse", 32'(mis3), 32'(has && r.mis));
        check("dut3 early done", 32'(done3), 32'h0);
        if (pc_hold) begin
            check("pcSrc dut0 before busy", 32'(pc0), 32'h1);
            check("pcSrc dut3 before busy", 32'(pc3), 32'h1);
            ctrl_branch_ne = 1'b1;
        end
        ctrl_memRead        = 1'b0;
        ctrl_memWrite       = 1'b0;
        ctrl_size           = 2'($urandom_range(0, 3));
        ctrl_unsigned       = 1'($urandom_range(0, 1));
        mem_address         = $urandom;
        write_data_into_mem = $urandom;
        if (abort3) return;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk);
            #1;
            check("dut3 busy window", 32'(busy3), 32'((k < 3) && valid));
            check("dut3 done latency", 32'(done3), 32'((k == 3) && valid));
            check("dut0 idle busy", 32'(busy0), 32'h0);
            if (pc_hold) begin
                check("pcSrc dut0 follows", 32'(pc0), 32'h0);
                check("pcSrc dut3 holds", 32'(pc3), 32'h1);
            end
        end
    endtask

    task automatic req(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd);
        do_req(rd, wr, sz, uns, addr, wd, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " dut0 pcSrc"}, 32'(pc0), 32'h0);
        check({tag, " dut0 read_data"}, rd0, 32'h0);
        check({tag, " dut0 busy"}, 32'(busy0), 32'h0);
        check({tag, " dut0 done"}, 32'(done0), 32'h0);
        check({tag, " dut0 misaligned"}, 32'(mis0), 32'h0);
        check({tag, " dut3 pcSrc"}, 32'(pc3), 32'h0);
        check({tag, " dut3 read_data"}, rd3, 32'h0);
        check({tag, " dut3 busy"}, 32'(busy3), 32'h0);
        check({tag, " dut3 done"}, 32'(done3), 32'h0);
        check({tag, " dut3 misaligned"}, 32'(mis3), 32'h0);
    endtask

    task automatic branch_step(input bit br, input bit z, input bit ne);
        @(negedge clk);
        ctrl_branch    = br;
        zero           = z;
        ctrl_branch_ne = ne;
        @(posedge clk);
        #1;
        check("pcSrc dut0", 32'(pc0), 32'(br & (z ^ ne)));
        check("pcSrc dut3", 32'(pc3), 32'(br & (z ^ ne)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ctrl_branch = 1'b0; ctrl_branch_ne = 1'b0; zero = 1'b0;
        ctrl_memRead = 1'b0; ctrl_memWrite = 1'b0; ctrl_size = 2'd0; ctrl_unsigned = 1'b0;
        mem_address = 32'h0; write_data_into_mem = 32'h0;
        model_reset();
        #2 reset = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        req(0, 1, 2'd2, 0, 32'h10, 32'hDEAD_BEEF);
        req(1, 0, 2'd2, 0, 32'h10, 32'h0);

        req(0, 1, 2'd2, 0, 32'h20, 32'h80FF_7F01);
        req(1, 0, 2'd0, 0, 32'h21, 32'h0);
        req(1, 0, 2'd0, 0, 32'h22, 32'h0);
        req(1, 0, 2'd1, 1, 32'h22, 32'h0);
        req(1, 0, 2'd1, 0, 32'h22, 32'h0);

        req(0, 1, 2'd2, 0, 32'h30, 32'h1122_3344);
        req(0, 1, 2'd0, 0, 32'h31, 32'h5555_55AA);
        req(1, 0, 2'd2, 0, 32'h30, 32'h0);
        req(1, 0, 2'd2, 0, 32'h32, 32'h0);
        req(0, 1, 2'd1, 0, 32'h33, 32'hBBBB_CCCC);
        req(1, 0, 2'd3, 0, 32'h30, 32'h0);

        req(1, 1, 2'd1, 0, 32'h42, 32'h0000_8001);
        req(1, 0, 2'd1, 0, 32'h1042, 32'h0);

        branch_step(1, 1, 0);
        branch_step(1, 1, 1);
        branch_step(1, 0, 1);
        branch_step(0, 1, 0);
        branch_step(1, 1, 0);
        do_req(1, 0, 2'd2, 0, 32'h10, 32'h0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check("pcSrc dut3 after busy", 32'(pc3), 32'h0);
        check("pcSrc dut0 after busy", 32'(pc0), 32'h0);

        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
            req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), a, $urandom);
        end

        branch_step(1, 0, 1);
        do_req(0, 1, 2'd2, 0, 32'h50, 32'hCAFE_F00D, 1'b1, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("reset mid-access");
        @(posedge clk);
        #1 check_all_zero("held in reset");
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        req(1, 0, 2'd2, 0, 32'h50, 32'h0);
        req(1, 0, 2'd2, 0, 32'h30, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("dut0 responses outstanding", 32'(sb0.size()), 32'h0);
        check("dut3 responses outstanding", 32'(sb3.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
